// File: rtl/fpu_operand_stage.sv
// Operand front end for the fixed-point FPU: per-lane source select, fp32 to fixed
// conversion, negation and saturation, registered through a two-stage valid/ready pipe.
module fpu_operand_stage #(
    parameter int LANES  = 2,
    parameter int FIX_W  = 64,
    parameter int FRAC_W = 32,
    parameter int TAG_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*LANES-1:0]       src,
    input  logic [32*LANES-1:0]      rs_data,
    input  logic [FIX_W*LANES-1:0]   xs_data,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FIX_W*LANES-1:0]   data,
    output logic [LANES-1:0]         sat,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int INT_W = FIX_W - FRAC_W;
    localparam logic signed [FIX_W-1:0] MAX_V = {1'b0, {(FIX_W-1){1'b1}}};
    localparam logic signed [FIX_W-1:0] MIN_V = {1'b1, {(FIX_W-1){1'b0}}};
    localparam logic signed [FIX_W-1:0] ONE_V = {{(INT_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    localparam logic [1:0] SRC_FP  = 2'b00;
    localparam logic [1:0] SRC_ONE = 2'b01;
    localparam logic [1:0] SRC_XS  = 2'b10;

    typedef struct packed {
        logic                    sat;
        logic signed [FIX_W-1:0] val;
    } res_t;

    function automatic res_t fp_to_fix(
        input logic              sign,
        input logic signed [9:0] e,
        input logic [23:0]       sig,
        input logic              zd,
        input logic              inf,
        input logic              nan
    );
        res_t             r;
        int               sh;
        logic [FIX_W-1:0] ext;
        logic [FIX_W-1:0] mag;
        r   = '0;
        sh  = FRAC_W + int'(e) - 23;
        ext = {{(FIX_W-24){1'b0}}, sig};
        mag = '0;
        if (nan) begin
            r.sat = 1'b1;
        end else if (zd) begin
            r.val = '0;
        end else if (inf || int'(e) >= INT_W - 1) begin
            // -2^(INT_W-1) is exactly the most negative code, so it is not a saturation
            if (sign && !inf && int'(e) == INT_W - 1 && sig == 24'h800000) begin
                r.val = MIN_V;
            end else begin
                r.sat = 1'b1;
                r.val = sign ? MIN_V : MAX_V;
            end
        end else begin
            if (sh >= 0) begin
                mag = ext << sh;
            end else if (sh >= -24) begin
                mag = ext >> (-sh);
            end
            r.val = sign ? -$signed(mag) : $signed(mag);
        end
        return r;
    endfunction

    function automatic res_t neg_fix(input logic signed [FIX_W-1:0] x);
        res_t r;
        if (x == MIN_V) begin
            r.sat = 1'b1;
            r.val = MAX_V;
        end else begin
            r.sat = 1'b0;
            r.val = -x;
        end
        return r;
    endfunction

    logic vld_p1;
    logic vld_p2;
    logic s2_free;
    logic in_fire;

    assign s2_free  = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_free;
    assign in_fire  = in_valid && in_ready;

    // S1: decode
    logic [TAG_W-1:0]        tag_p1;
    logic [1:0]              src_p1  [LANES];
    logic                    sign_p1 [LANES];
    logic signed [9:0]       exp_p1  [LANES];
    logic [23:0]             sig_p1  [LANES];
    logic                    zd_p1   [LANES];
    logic                    inf_p1  [LANES];
    logic                    nan_p1  [LANES];
    logic signed [FIX_W-1:0] xs_p1   [LANES];

    always_ff @(posedge clk) begin
        if (in_fire) begin
            tag_p1 <= in_tag;
            for (int i = 0; i < LANES; i++) begin
                src_p1[i]  <= src[2*i +: 2];
                sign_p1[i] <= rs_data[32*i + 31];
                exp_p1[i]  <= $signed({2'b00, rs_data[32*i + 23 +: 8]}) - 10'sd127;
                sig_p1[i]  <= {1'b1, rs_data[32*i +: 23]};
                zd_p1[i]   <= (rs_data[32*i + 23 +: 8] == 8'h00);
                inf_p1[i]  <= (rs_data[32*i + 23 +: 8] == 8'hFF) && (rs_data[32*i +: 23] == 23'd0);
                nan_p1[i]  <= (rs_data[32*i + 23 +: 8] == 8'hFF) && (rs_data[32*i +: 23] != 23'd0);
                xs_p1[i]   <= $signed(xs_data[FIX_W*i +: FIX_W]);
            end
        end
    end

    // S2: execute (shift, negate, saturate, select)
    res_t res_p1 [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            res_p1[i] = '0;
            case (src_p1[i])
                SRC_FP:  res_p1[i] = fp_to_fix(sign_p1[i], exp_p1[i], sig_p1[i],
                                               zd_p1[i], inf_p1[i], nan_p1[i]);
                SRC_ONE: res_p1[i].val = ONE_V;
                SRC_XS:  res_p1[i].val = xs_p1[i];
                default: res_p1[i] = neg_fix(xs_p1[i]);
            endcase
        end
    end

    logic [FIX_W*LANES-1:0] data_p2;
    logic [LANES-1:0]       sat_p2;
    logic [TAG_W-1:0]       tag_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            sat_p2  <= '0;
            tag_p2  <= '0;
        end else begin
            if (in_fire) begin
                vld_p1 <= 1'b1;
            end else if (s2_free) begin
                vld_p1 <= 1'b0;
            end
            if (s2_free) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    tag_p2 <= tag_p1;
                    for (int i = 0; i < LANES; i++) begin
                        data_p2[FIX_W*i +: FIX_W] <= res_p1[i].val;
                        sat_p2[i]                 <= res_p1[i].sat;
                    end
                end
            end
        end
    end

    assign out_valid = vld_p2;
    assign data      = data_p2;
    assign sat       = sat_p2;
    assign out_tag   = tag_p2;

endmodule

// File: tb/tb_fpu_operand_stage.sv
// Bench for fpu_operand_stage: directed boundary cases plus randomized streams
// scored against a real-arithmetic model of the conversion rules.
module tb_fpu_operand_stage;

    localparam int LANES  = 2;
    localparam int FIX_W  = 64;
    localparam int FRAC_W = 32;
    localparam int TAG_W  = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   src;
    logic [63:0]  rs_data;
    logic [127:0] xs_data;
    logic [7:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data;
    logic [1:0]   sat;
    logic [7:0]   out_tag;

    fpu_operand_stage #(
        .LANES(LANES), .FIX_W(FIX_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .src(src), .rs_data(rs_data), .xs_data(xs_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .data(data), .sat(sat),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic [1:0]   s;
        logic [7:0]   t;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           n_acc = 0;
    int           n_out = 0;
    logic         hold_on = 1'b0;
    logic [127:0] hold_d;
    logic [1:0]   hold_s;
    logic [7:0]   hold_t;
    logic [7:0]   dtag = 8'h60;

    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    task automatic check(input string nm, input logic [127:0] obs, input logic [127:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, want);
        end
    endtask

    // value of the fp32 word scaled by 2^FRAC_W, truncated toward zero, then clamped
    function automatic logic [64:0] model_lane(input logic [1:0] s, input logic [31:0] rs,
                                               input logic [63:0] xs);
        int          ex;
        real         mag;
        real         t;
        real         lim;
        logic [63:0] v;
        lim = 2.0 ** (FIX_W - 1);
        case (s)
            2'b01: return {1'b0, 64'd1 << FRAC_W};
            2'b10: return {1'b0, xs};
            2'b11: return (xs == MINV) ? {1'b1, MAXV} : {1'b0, -xs};
            default: begin
                ex = int'(rs[30:23]);
                if (ex == 255) return (rs[22:0] != 23'd0) ? {1'b1, 64'h0} : {1'b1, rs[31] ? MINV : MAXV};
                if (ex == 0) return 65'h0;
                mag = (1.0 + real'(rs[22:0]) / 8388608.0) * (2.0 ** (ex - 127 + FRAC_W));
                t = $floor(mag);
                if (rs[31]) begin
                    if (t > lim) return {1'b1, MINV};
                    if (t == lim) return {1'b0, MINV};
                    v = longint'(t);
                    return {1'b0, -v};
                end
                if (t >= lim) return {1'b1, MAXV};
                v = longint'(t);
                return {1'b0, v};
            end
        endcase
    endfunction

    function automatic exp_t model(input logic [3:0] s, input logic [63:0] rs,
                                   input logic [127:0] xs, input logic [7:0] tg);
        exp_t        e;
        logic [64:0] l0;
        logic [64:0] l1;
        l0 = model_lane(s[1:0], rs[31:0], xs[63:0]);
        l1 = model_lane(s[3:2], rs[63:32], xs[127:64]);
        e.d = {l1[63:0], l0[63:0]};
        e.s = {l1[64], l0[64]};
        e.t = tg;
        return e;
    endfunction

    function automatic logic [31:0] rand_fp();
        int k;
        k = $urandom_range(0, 15);
        case (k)
            0: return 32'h7FC0_0000;
            1: return 32'hFF80_0000;
            2: return 32'h4F00_0000;
            3: return 32'hCF00_0000;
            4: return {1'($urandom), 8'h00, 23'($urandom)};
            default: return {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
        endcase
    endfunction

    function automatic logic [63:0] rand_xs();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return MINV;
        if (k == 1) return 64'h0000_0001_0000_0000;
        return {$urandom, $urandom};
    endfunction

    task automatic randomize_inputs();
        src     = 4'($urandom);
        rs_data = {rand_fp(), rand_fp()};
        xs_data = {rand_xs(), rand_xs()};
    endtask

    // one clock: sample mid-cycle, score handshakes, advance to the next falling edge
    task automatic tick();
        exp_t e;
        #1;
        if (hold_on) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", data, hold_d);
            check("stall_sat", sat, hold_s);
            check("stall_tag", out_tag, hold_t);
        end
        check("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
        if (out_valid && out_ready) begin
            n_out++;
            check("out_pending", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", data, e.d);
                check("out_sat", sat, e.s);
                check("out_tag", out_tag, e.t);
            end
        end
        hold_on = out_valid && !out_ready;
        hold_d  = data;
        hold_s  = sat;
        hold_t  = out_tag;
        if (in_valid && in_ready) begin
            n_acc++;
            sb.push_back(model(src, rs_data, xs_data, in_tag));
        end
        @(negedge clk);
    endtask

    task automatic directed(input string nm, input logic [3:0] s, input logic [63:0] rs,
                            input logic [127:0] xs, input logic [127:0] ed, input logic [1:0] es);
        src       = s;
        rs_data   = rs;
        xs_data   = xs;
        in_tag    = dtag;
        dtag      = dtag + 8'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check({nm, "_valid"}, out_valid, 1'b1);
        check({nm, "_data"}, data, ed);
        check({nm, "_sat"}, sat, es);
        tick();
    endtask

    initial begin
        int acc0;
        int out0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        src       = '0;
        rs_data   = '0;
        xs_data   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_data", data, 128'h0);
        check("rst_sat", sat, 2'b00);
        check("rst_tag", out_tag, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // two-cycle latency on a single transfer
        src      = 4'b0000;
        rs_data  = {32'hC020_0000, 32'h3F80_0000};
        in_tag   = 8'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat1_valid", out_valid, 1'b0);
        tick();
        check("lat2_valid", out_valid, 1'b1);
        check("lat2_data", data, {64'hFFFF_FFFD_8000_0000, 64'h0000_0001_0000_0000});
        check("lat2_sat", sat, 2'b00);
        check("lat2_tag", out_tag, 8'h01);
        tick();

        directed("fp_big", 4'b0000, {32'hCF00_0000, 32'h4F00_0000}, 128'h0, {MINV, MAXV}, 2'b01);
        directed("fp_tiny", 4'b0000, {32'h2F00_0000, 32'h2F80_0000}, 128'h0, {64'h0, 64'h1}, 2'b00);
        directed("fp_nan_inf", 4'b0000, {32'hFF80_0000, 32'h7FC0_0000}, 128'h0, {MINV, 64'h0}, 2'b11);
        directed("src_one_xs", 4'b1001, 64'h0, {MINV, 64'h0}, {MINV, 64'h0000_0001_0000_0000}, 2'b00);
        directed("src_neg", 4'b1111, 64'h0, {MINV, 64'h0000_0001_0000_0000},
                 {MAXV, 64'hFFFF_FFFF_0000_0000}, 2'b10);

        // tags 1..8 under random backpressure
        acc0 = n_acc;
        out0 = n_out;
        for (int c = 0; c < 300 && (n_out - out0) < 8; c++) begin
            in_valid  = (n_acc - acc0) < 8;
            in_tag    = 8'(n_acc - acc0 + 1);
            out_ready = 1'($urandom_range(0, 1));
            randomize_inputs();
            tick();
        end
        check("bp_out_count", n_out - out0, 8);
        check("bp_drained", sb.size(), 0);

        // full rate: one output per cycle after a two-cycle fill
        out_ready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            in_valid = (i < 20);
            in_tag   = 8'(16 + i);
            randomize_inputs();
            check("fr_valid", out_valid, (i >= 2 && i < 22));
            tick();
        end

        // longer random stream with random valid and ready
        acc0 = n_acc;
        out0 = n_out;
        for (int c = 0; c < 600 && (n_out - out0) < 60; c++) begin
            in_valid  = ((n_acc - acc0) < 60) && ($urandom_range(0, 3) != 0);
            in_tag    = 8'(64 + n_acc - acc0);
            out_ready = ($urandom_range(0, 2) != 0);
            randomize_inputs();
            tick();
        end
        check("rnd_out_count", n_out - out0, 60);
        check("rnd_drained", sb.size(), 0);

        // asynchronous reset with two transfers in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 8'hA1;
        randomize_inputs();
        tick();
        in_tag = 8'hA2;
        randomize_inputs();
        tick();
        in_valid = 1'b0;
        check("rst2_pre_valid", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst2_out_valid", out_valid, 1'b0);
        check("rst2_in_ready", in_ready, 1'b1);
        check("rst2_data", data, 128'h0);
        check("rst2_sat", sat, 2'b00);
        check("rst2_tag", out_tag, 8'h00);
        sb.delete();
        hold_on = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("rst2_no_output", out_valid, 1'b0);
            tick();
        end
        directed("post_rst", 4'b0001, {32'h3F80_0000, 32'h0}, 128'h0,
                 {64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
